pulse_period_checker: RTL and testbench

Downstream monitor for the 4-bit counter stage. It watches the counter's `out` pulse and `count` bus and measures the clock-cycle period between successive rising edges of `out`. It compares each period against an expected value and reports lock, mismatch and timeout status to the bench or system controller.

---
 rtl/pulse_period_checker.sv | 218 +++++++++++++++++++++
 tb/tb_pulse_period_checker.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pulse_period_checker.sv
// ---------------------------------------------------------------------------
// pulse_period_checker
//
// Monitors the pulse output of the upstream 4-bit counter stage. It measures
// the clock-cycle period between successive rising edges of pulse_in and
// compares each period against EXP_PERIOD +/- TOL. It reports lock after
// LOCK_N consecutive matches, a one-cycle mismatch strobe on a failed check
// or timeout, a sticky error flag, and a count of rising edges.
//
// Optional build macro:
//   PPC_COUNT_CHECK_EN - when defined, each checked rising edge must also
//                        see count_in == EXP_COUNT. When undefined,
//                        count_in is ignored.
//
// Parameters:
//   EXP_PERIOD   expected cycles between consecutive rising edges
//   TOL          allowed absolute deviation from EXP_PERIOD
//   LOCK_N       consecutive matching periods needed for lock (>= 1)
//   CNT_W        width of the period counter and of the period output
//   EXP_COUNT    expected count_in at each rise (macro build only)
//
// Ports:
//   clk          clock, all logic is posedge
//   reset        asynchronous active-low reset
//   pulse_in     upstream pulse
//   count_in     upstream count bus
//   clr          synchronous clear of err_sticky and edge_cnt
//   period       last measured period
//   period_valid one-cycle strobe when period updates
//   mismatch     one-cycle strobe on a failed check or timeout
//   locked       high after LOCK_N consecutive matches
//   err_sticky   set by any mismatch, cleared by clr or reset
//   edge_cnt     rising edges seen, wraps 255 -> 0
// ---------------------------------------------------------------------------
module pulse_period_checker #(
    parameter int         EXP_PERIOD = 16,
    parameter int         TOL        = 0,
    parameter int         LOCK_N     = 2,
    parameter int         CNT_W      = 8,
    parameter logic [3:0] EXP_COUNT  = 4'd0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pulse_in,
    input  logic [3:0]       count_in,
    input  logic             clr,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             mismatch,
    output logic             locked,
    output logic             err_sticky,
    output logic [7:0]       edge_cnt
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MEASURE = 2'd1,
        S_LOCKED  = 2'd2
    } state_t;

    localparam int                MW      = $clog2(LOCK_N + 1);
    localparam logic [MW-1:0]     LP_LOCK = MW'(LOCK_N);
    localparam logic [CNT_W:0]    LP_EXP  = (CNT_W + 1)'(EXP_PERIOD);
    localparam logic [CNT_W:0]    LP_TOL  = (CNT_W + 1)'(TOL);
    localparam logic [CNT_W-1:0]  PC_MAX  = '1;

    state_t           r_state;
    logic             r_prev;
    logic [CNT_W-1:0] r_pc;
    logic [MW-1:0]    r_match;
    logic [CNT_W-1:0] r_period;
    logic             r_pv;
    logic             r_mis;
    logic             r_locked;
    logic             r_err;
    logic [7:0]       r_edge;

    logic             w_rise;
    logic             w_sat;
    logic [CNT_W:0]   w_pc_ext;
    logic [CNT_W:0]   w_diff;
    logic             w_per_ok;
    logic             w_cnt_ok;
    logic             w_chk_ok;
    logic             w_mis_nxt;
    logic [MW-1:0]    w_match_inc;

    assign w_rise   = pulse_in & ~r_prev;
    assign w_sat    = (r_pc == PC_MAX);

    // Absolute difference, one bit wider so neither direction wraps.
    assign w_pc_ext = {1'b0, r_pc};
    assign w_diff   = (w_pc_ext >= LP_EXP) ? (w_pc_ext - LP_EXP) : (LP_EXP - w_pc_ext);
    assign w_per_ok = (w_diff <= LP_TOL);

`ifdef PPC_COUNT_CHECK_EN
    assign w_cnt_ok = (count_in == EXP_COUNT);
`else
    logic w_unused_count;
    assign w_unused_count = ^{count_in, EXP_COUNT};
    assign w_cnt_ok       = 1'b1;
`endif

    assign w_chk_ok    = w_per_ok & w_cnt_ok;
    assign w_match_inc = r_match + MW'(1);

    // A rise always wins over saturation: the saturated value is measured
    // and checked instead of raising a timeout.
    assign w_mis_nxt = (r_state != S_IDLE) && (w_rise ? ~w_chk_ok : w_sat);

    // Edge detector and free-running, saturating period counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prev <= 1'b0;
            r_pc   <= '0;
        end else begin
            r_prev <= pulse_in;
            if (w_rise)
                r_pc <= CNT_W'(1);
            else if (!w_sat)
                r_pc <= r_pc + CNT_W'(1);
        end
    end

    // Sticky error and edge counter. A same-cycle mismatch beats clr for the
    // error flag; clr beats a same-cycle rise for the edge counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err  <= 1'b0;
            r_edge <= '0;
        end else begin
            if (w_mis_nxt)
                r_err <= 1'b1;
            else if (clr)
                r_err <= 1'b0;

            if (clr)
                r_edge <= '0;
            else if (w_rise)
                r_edge <= r_edge + 8'd1;
        end
    end

    // Measurement FSM with registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_match  <= '0;
            r_period <= '0;
            r_pv     <= 1'b0;
            r_mis    <= 1'b0;
            r_locked <= 1'b0;
        end else begin
            r_pv  <= 1'b0;
            r_mis <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // First rise only arms; the partial period is unknown.
                    if (w_rise) begin
                        r_state <= S_MEASURE;
                        r_match <= '0;
                    end
                end
                S_MEASURE: begin
                    if (w_rise) begin
                        r_period <= r_pc;
                        r_pv     <= 1'b1;
                        if (w_chk_ok) begin
                            r_match <= w_match_inc;
                            if (w_match_inc == LP_LOCK) begin
                                r_locked <= 1'b1;
                                r_state  <= S_LOCKED;
                            end
                        end else begin
                            r_mis   <= 1'b1;
                            r_match <= '0;
                        end
                    end else if (w_sat) begin
                        r_mis    <= 1'b1;
                        r_match  <= '0;
                        r_locked <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                S_LOCKED: begin
                    if (w_rise) begin
                        r_period <= r_pc;
                        r_pv     <= 1'b1;
                        if (!w_chk_ok) begin
                            r_mis    <= 1'b1;
                            r_match  <= '0;
                            r_locked <= 1'b0;
                            r_state  <= S_MEASURE;
                        end
                    end else if (w_sat) begin
                        r_mis    <= 1'b1;
                        r_match  <= '0;
                        r_locked <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_match  <= '0;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    assign period       = r_period;
    assign period_valid = r_pv;
    assign mismatch     = r_mis;
    assign locked       = r_locked;
    assign err_sticky   = r_err;
    assign edge_cnt     = r_edge;

endmodule

// File: tb/tb_pulse_period_checker.sv
module tb_pulse_period_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic       pulse_in;
    logic [3:0] count_in;
    logic       clr;

    logic [7:0] period, t_period;
    logic       pv, t_pv, mis, t_mis, lk, t_lk, err, t_err;
    logic [7:0] edges, t_edges;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pulse_period_checker dut (
        .clk(clk), .reset(reset), .pulse_in(pulse_in), .count_in(count_in), .clr(clr),
        .period(period), .period_valid(pv), .mismatch(mis), .locked(lk),
        .err_sticky(err), .edge_cnt(edges)
    );

    pulse_period_checker #(.TOL(1)) dut_tol (
        .clk(clk), .reset(reset), .pulse_in(pulse_in), .count_in(count_in), .clr(clr),
        .period(t_period), .period_valid(t_pv), .mismatch(t_mis), .locked(t_lk),
        .err_sticky(t_err), .edge_cnt(t_edges)
    );

    typedef struct {
        int   gap;
        int   per;
        logic pv;
        logic mis;
        logic lk;
        logic err;
        int   edges;
        logic tmis;
        logic tlk;
    } vec_t;

    vec_t tbl[13];

    function automatic vec_t mk(int gap, int per, logic v, logic m, logic l, logic e,
                                int ec, logic tm, logic tl);
        vec_t r;
        r.gap = gap; r.per = per; r.pv = v; r.mis = m; r.lk = l; r.err = e;
        r.edges = ec; r.tmis = tm; r.tlk = tl;
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge; the rise lands on the next posedge and its
    // registered results are visible on return.
    task automatic rise_now(input logic [3:0] cnt);
        pulse_in = 1'b1;
        count_in = cnt;
        @(negedge clk);
        pulse_in = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_main(input string tag, input int per, input logic v,
                            input logic m, input logic l);
        chk({tag, ".period"}, period, per);
        chk({tag, ".pv"}, pv, v);
        chk({tag, ".mis"}, mis, m);
        chk({tag, ".locked"}, lk, l);
    endtask

    initial begin
        int mis_cnt;

        tbl[0]  = mk( 5,  0, 0, 0, 0, 0,  1, 0, 0); // arming rise
        tbl[1]  = mk(16, 16, 1, 0, 0, 0,  2, 0, 0);
        tbl[2]  = mk(16, 16, 1, 0, 1, 0,  3, 0, 1); // second match locks
        tbl[3]  = mk(16, 16, 1, 0, 1, 0,  4, 0, 1);
        tbl[4]  = mk(16, 16, 1, 0, 1, 0,  5, 0, 1);
        tbl[5]  = mk(12, 12, 1, 1, 0, 1,  6, 1, 0); // short period
        tbl[6]  = mk(16, 16, 1, 0, 0, 1,  7, 0, 0);
        tbl[7]  = mk(16, 16, 1, 0, 1, 1,  8, 0, 1); // relocked
        tbl[8]  = mk(15, 15, 1, 1, 0, 1,  9, 0, 1); // TOL=1 instance accepts
        tbl[9]  = mk(17, 17, 1, 1, 0, 1, 10, 0, 1);
        tbl[10] = mk(17, 17, 1, 1, 0, 1, 11, 0, 1);
        tbl[11] = mk(16, 16, 1, 0, 0, 1, 12, 0, 1);
        tbl[12] = mk(16, 16, 1, 0, 1, 1, 13, 0, 1);

        reset = 1'b0; pulse_in = 1'b0; count_in = 4'd0; clr = 1'b0;
        #1;
        chk("rst.period", period, 0);
        chk("rst.pv", pv, 0);
        chk("rst.mis", mis, 0);
        chk("rst.locked", lk, 0);
        chk("rst.err", err, 0);
        chk("rst.edges", edges, 0);
        idle(3);
        reset = 1'b1;

        for (int i = 0; i < 13; i++) begin
            idle(tbl[i].gap - 1);
            rise_now(4'd0);
            chk_main($sformatf("v%0d", i), tbl[i].per, tbl[i].pv, tbl[i].mis, tbl[i].lk);
            chk($sformatf("v%0d.err", i), err, tbl[i].err);
            chk($sformatf("v%0d.edges", i), edges, tbl[i].edges);
            chk($sformatf("v%0d.tol_mis", i), t_mis, tbl[i].tmis);
            chk($sformatf("v%0d.tol_locked", i), t_lk, tbl[i].tlk);
        end

        // clr clears the sticky error and the edge counter.
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr.err", err, 0);
        chk("clr.edges", edges, 0);
        chk("clr.locked", lk, 1);

        // Timeout 255 cycles after the last rise, with clr in the same cycle:
        // err stays set, edge_cnt clears.
        idle(253);
        chk("pre_to.mis", mis, 0);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("to.mis", mis, 1);
        chk("to.err", err, 1);
        chk("to.edges", edges, 0);
        chk("to.locked", lk, 0);
        chk("to.period", period, 16);
        chk("to.pv", pv, 0);
        mis_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mis) mis_cnt++;
        end
        chk("to.no_repeat", mis_cnt, 0);

        // Relock from IDLE: arming rise, then two matching periods.
        rise_now(4'd0);
        chk_main("re0", 16, 0, 0, 0);
        chk("re0.edges", edges, 1);
        idle(15); rise_now(4'd0);
        chk_main("re1", 16, 1, 0, 0);
        idle(15); rise_now(4'd0);
        chk_main("re2", 16, 1, 0, 1);

        // Rise coinciding with saturation: measured as 255, check fails,
        // no timeout, FSM stays measuring.
        idle(254); rise_now(4'd0);
        chk_main("sat", 255, 1, 1, 0);
        idle(15); rise_now(4'd0);
        chk_main("sat_next", 16, 1, 0, 0);

        // Asynchronous reset mid-measurement.
        idle(5);
        reset = 1'b0;
        #1;
        chk("rst2.period", period, 0);
        chk("rst2.pv", pv, 0);
        chk("rst2.locked", lk, 0);
        chk("rst2.err", err, 0);
        chk("rst2.edges", edges, 0);
        idle(2);
        reset = 1'b1;
        idle(3); rise_now(4'd0);
        chk_main("rst2_arm", 0, 0, 0, 0);
        chk("rst2_arm.edges", edges, 1);
        idle(15); rise_now(4'd0);
        chk_main("rst2_m1", 16, 1, 0, 0);

        // count_in = 3 at each rise; only the count-check build rejects it.
        for (int i = 0; i < 3; i++) begin
            idle(15); rise_now(4'd3);
`ifdef PPC_COUNT_CHECK_EN
            chk_main($sformatf("cnt%0d", i), 16, 1, 1, 0);
`else
            chk_main($sformatf("cnt%0d", i), 16, 1, 0, 1);
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
